// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that sequences fetch, decode and
// per-class execute steps, and counts completed instructions.
module mips_mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_we,
  output logic        ir_we,
  output logic        i_or_d,
  output logic        mem_we,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic        jal_sel,
  output logic        halted,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_control,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTEXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_JR       = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;

  logic [3:0] state_q;
  logic [3:0] next_state;
  logic       rtype_ok;
  logic       retire;
  logic       pc_we_raw;
  logic       ir_we_raw;
  logic       mem_we_raw;
  logic       reg_we_raw;

  assign state = state_q;

  always_comb begin
    rtype_ok = 1'b0;
    case (funct)
      6'b000000, 6'b000010, 6'b100000, 6'b100010,
      6'b100100, 6'b100101, 6'b101010: rtype_ok = 1'b1;
      default:                         rtype_ok = 1'b0;
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          6'b100011, 6'b101011: next_state = S_MEMADR;
          6'b000000: begin
            if (rtype_ok)                next_state = S_RTEXEC;
            else if (funct == 6'b001000) next_state = S_JR;
            else                         next_state = S_HALT;
          end
          6'b000100, 6'b000101: next_state = S_BRANCH;
          6'b001000:            next_state = S_ADDIEXEC;
          6'b000011:            next_state = S_JAL;
          default:              next_state = S_HALT;
        endcase
      end
      S_MEMADR:   next_state = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next_state = S_MEMWB;
      S_RTEXEC:   next_state = S_ALUWB;
      S_ADDIEXEC: next_state = S_ADDIWB;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_FETCH;
    endcase
  end

  // Only states that finish an instruction count toward retired on return to FETCH.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH,
      S_ADDIWB, S_JAL, S_JR: retire = 1'b1;
      default:               retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      retired <= 32'd0;
    end else begin
      state_q <= next_state;
      if (retire && (next_state == S_FETCH))
        retired <= retired + 32'd1;
    end
  end

  always_comb begin
    pc_we_raw   = 1'b0;
    ir_we_raw   = 1'b0;
    mem_we_raw  = 1'b0;
    reg_we_raw  = 1'b0;
    i_or_d      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    jal_sel     = 1'b0;
    halted      = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = 3'b000;
    case (state_q)
      S_FETCH: begin
        ir_we_raw   = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = 3'b010;
        pc_we_raw   = 1'b1;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = 3'b010;
      end
      S_MEMADR, S_ADDIEXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = 3'b010;
      end
      S_MEMRD: i_or_d = 1'b1;
      S_MEMWB: begin
        reg_we_raw = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        i_or_d     = 1'b1;
        mem_we_raw = 1'b1;
      end
      S_RTEXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          6'b000000: alu_control = 3'b100;
          6'b000010: alu_control = 3'b101;
          6'b100000: alu_control = 3'b010;
          6'b100010: alu_control = 3'b110;
          6'b100100: alu_control = 3'b000;
          6'b100101: alu_control = 3'b001;
          6'b101010: alu_control = 3'b111;
          default:   alu_control = 3'b000;
        endcase
      end
      S_ALUWB: begin
        reg_we_raw = 1'b1;
        reg_dst    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        pc_src      = 2'b01;
        pc_we_raw   = zero ^ (op == 6'b000101);
      end
      S_ADDIWB: reg_we_raw = 1'b1;
      S_JAL: begin
        reg_we_raw = 1'b1;
        jal_sel    = 1'b1;
        pc_src     = 2'b10;
        pc_we_raw  = 1'b1;
      end
      S_JR: begin
        pc_src    = 2'b11;
        pc_we_raw = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // Write enables are suppressed for the whole reset cycle, whatever state we are in.
  assign pc_we  = pc_we_raw  & ~reset;
  assign ir_we  = ir_we_raw  & ~reset;
  assign mem_we = mem_we_raw & ~reset;
  assign reg_we = reg_we_raw & ~reset;

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: op  input  6  opcode field of the held instruction register; stable from DECODE onward.
REQ-004 SHALL have port: funct  input  6  function field of the held instruction register.
REQ-005 SHALL have port: zero  input  1  ALU zero flag.
REQ-006 SHALL have outputs (all 1 bit): pc_we, ir_we, i_or_d, mem_we, reg_we, reg_dst, mem_to_reg, alu_src_a, jal_sel, halted.
REQ-007 SHALL have outputs: alu_src_b  2  (00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2); pc_src  2  (00 ALU result, 01 ALUOut, 10 jump target, 11 reg A).
REQ-008 SHALL have outputs: alu_control  3; state  4; retired  32  count of completed instructions.

Function
REQ-009 SHALL implement a Moore FSM; all control outputs are decoded from state, plus funct in RTEXEC and zero/op in BRANCH.
REQ-010 SHALL encode states as: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JAL=11, JR=12, HALT=13.
REQ-011 SHALL drive every output 0 by default in any state not listed below.
REQ-012 FETCH SHALL drive: ir_we=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00, pc_we=1; next state DECODE.
REQ-013 DECODE SHALL drive: alu_src_a=0, alu_src_b=11, alu_control=010 (branch target into ALUOut).
REQ-014 DECODE SHALL transition: op 100011/101011 -> MEMADR; op 000000 with funct in {000000, 000010, 100000, 100010, 100100, 100101, 101010} -> RTEXEC; op 000000 & funct 001000 -> JR; op 000100/000101 -> BRANCH; op 001000 -> ADDIEXEC; op 000011 -> JAL; anything else -> HALT.
REQ-015 MEMADR SHALL drive: alu_src_a=1, alu_src_b=10, alu_control=010; next MEMRD if op=100011, else MEMWR.
REQ-016 MEMRD SHALL drive i_or_d=1; next MEMWB.
REQ-017 MEMWB SHALL drive: reg_we=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-018 MEMWR SHALL drive: i_or_d=1, mem_we=1; next FETCH.
REQ-019 RTEXEC SHALL drive: alu_src_a=1, alu_src_b=00, alu_control by funct: 000000->100, 000010->101, 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; next ALUWB.
REQ-020 ALUWB SHALL drive: reg_we=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-021 BRANCH SHALL drive: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_we=zero XOR (op==000101); next FETCH.
REQ-022 ADDIEXEC SHALL drive: alu_src_a=1, alu_src_b=10, alu_control=010; next ADDIWB.
REQ-023 ADDIWB SHALL drive: reg_we=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-024 JAL SHALL drive: reg_we=1, jal_sel=1 (dest r31, data = PC, already PC+4), pc_src=10, pc_we=1; next FETCH.
REQ-025 JR SHALL drive: pc_src=11, pc_we=1; next FETCH.
REQ-026 HALT SHALL drive halted=1 with all write enables 0, and SHALL remain in HALT until reset.
REQ-027 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JAL or JR, wrapping from 0xFFFFFFFF to 0.
REQ-028 Cycle counts (FETCH inclusive) SHALL be: LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, JAL 3, JR 3.
REQ-029 state output SHALL equal the current state encoding.

Reset
REQ-030 reset=1 at a rising edge SHALL set state=FETCH and retired=0, overriding any transition including exit from HALT.
REQ-031 While reset=1, pc_we, ir_we, mem_we and reg_we SHALL be forced 0 regardless of state.
REQ-032 Deasserting reset mid-instruction SHALL abandon that instruction; the first cycle after release is FETCH.

Verification
REQ-033 Reset then op=100011 -> states 0,1,2,3,4,0; reg_we=1 and mem_to_reg=1 only in state 4; retired=1.
REQ-034 op=000000, funct=100010 -> states 0,1,6,7,0; alu_control=110 in state 6; reg_dst=1 in state 7.
REQ-035 op=000101: with zero=0 -> pc_we=1 in BRANCH; with zero=1 -> pc_we=0; both runs take 3 cycles and increment retired.
REQ-036 op=000011 -> states 0,1,11,0; jal_sel=1, reg_we=1, pc_src=10 in state 11.
REQ-037 op=111111 -> DECODE then HALT; halted=1 held for 20 cycles with retired unchanged; reset -> FETCH and retired=0.
REQ-038 Assert reset during MEMWR -> mem_we=0 that cycle; state=FETCH on the next edge.
